// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer and the decoder that feeds it.
// Holds the run-state enum, branch-class opcodes and the default start address.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } seq_state_t;

    typedef logic [4:0] opcode_t;

    localparam opcode_t kBRC = 5'h08;
    localparam opcode_t kBRR = 5'h09;
    localparam opcode_t kBRO = 5'h0A;

    localparam int unsigned kSTART_ADDR = 0;
    localparam int unsigned kOFFSET_W   = 9;

    // Decoder helper: BRANCH is asserted for any of the branch-class opcodes.
    function automatic logic is_branch_op(input opcode_t op);
        return (op == kBRC) || (op == kBRR) || (op == kBRO);
    endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC unit: sequential increment or signed-magnitude branch,
// wrapping modulo 2^PW in both directions.
module pc_next
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned PW = 10
) (
    input  logic [PW-1:0]        pc,
    input  logic [kOFFSET_W-1:0] offset,
    input  logic                 sign,
    input  logic                 branch,
    output logic [PW-1:0]        pc_nx
);

    // One guard bit above the wider operand so neither direction overflows before truncation.
    localparam int unsigned AW = ((PW > kOFFSET_W) ? PW : kOFFSET_W) + 1;

    logic [AW-1:0] pc_ext;
    logic [AW-1:0] off_ext;
    logic [AW-1:0] sum;

    always_comb begin
        pc_ext  = AW'(pc);
        off_ext = AW'(offset);
        if (!branch) begin
            sum = pc_ext + AW'(1);
        end else if (sign) begin
            sum = pc_ext - off_ext;
        end else begin
            sum = pc_ext + off_ext;
        end
        pc_nx = PW'(sum);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter and run controller: start/done handshake, next-PC selection,
// retired-instruction counter and runaway-program watchdog.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned PW         = 10,
    parameter int unsigned START_ADDR = kSTART_ADDR,
    parameter int unsigned CW         = 16,
    parameter int unsigned MAX_CYCLES = 16'hFFFF
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 START,
    input  logic                 STALL,
    input  logic                 BRANCH,
    input  logic [kOFFSET_W-1:0] bOFFSET,
    input  logic                 bSIGN,
    input  logic                 ALU_RST,
    input  logic                 ALU_HALT,
    output logic [PW-1:0]        PC,
    output logic                 COMMIT,
    output logic                 DONE,
    output logic                 TIMEOUT,
    output logic [CW-1:0]        INSTR_CNT,
    output logic [1:0]           STATE
);

    localparam logic [PW-1:0] START_PC = PW'(START_ADDR);

    seq_state_t    state;
    seq_state_t    state_nx;
    logic [PW-1:0] pc_q;
    logic [PW-1:0] pc_adv;
    logic [CW-1:0] icnt_q;
    logic [31:0]   cyc_cnt;
    logic          timeout_q;
    logic          done_q;

    logic in_run;
    logic launch;
    logic halt_req;
    logic soft_rst;
    logic wd_fire;

    pc_next #(.PW(PW)) u_pc_next (
        .pc     (pc_q),
        .offset (bOFFSET),
        .sign   (bSIGN),
        .branch (BRANCH),
        .pc_nx  (pc_adv)
    );

    // Stalled cycles see no halt/reset/branch: every control decision is qualified by COMMIT.
    always_comb begin
        in_run   = (state == RUN);
        launch   = START && ((state == IDLE) || (state == HALTED));
        halt_req = COMMIT && ALU_RST && ALU_HALT;
        soft_rst = COMMIT && ALU_RST && !ALU_HALT;
        wd_fire  = in_run && (MAX_CYCLES != 0) && ((cyc_cnt + 32'd1) == MAX_CYCLES);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin : state_reg
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin : next_state
        state_nx = state;
        case (state)
            IDLE:    if (START) state_nx = RUN;
            RUN:     if (halt_req || wd_fire) state_nx = HALTED;
            HALTED:  if (START) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin : outputs
        COMMIT = (state == RUN) && !STALL;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin : datapath
        if (!RESET_N) begin
            pc_q      <= START_PC;
            icnt_q    <= '0;
            cyc_cnt   <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_nx == HALTED);
            if (launch) begin
                pc_q      <= START_PC;
                icnt_q    <= '0;
                cyc_cnt   <= '0;
                timeout_q <= 1'b0;
            end else if (in_run) begin
                cyc_cnt <= cyc_cnt + 32'd1;
                if (COMMIT && (icnt_q != '1)) begin
                    icnt_q <= icnt_q + CW'(1);
                end
                if (wd_fire && !halt_req) begin
                    timeout_q <= 1'b1;
                end
                // A halting cycle (requested or forced) retires but leaves the PC on that instruction.
                if (COMMIT && !halt_req && !wd_fire) begin
                    pc_q <= soft_rst ? START_PC : pc_adv;
                end
            end
        end
    end

    assign PC        = pc_q;
    assign DONE      = done_q;
    assign TIMEOUT   = timeout_q;
    assign INSTR_CNT = icnt_q;
    assign STATE     = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized stimulus
// compared against an arithmetic reference model of the run controller.
module tb_pc_sequencer;

    localparam int unsigned PW      = 10;
    localparam int unsigned CW      = 5;
    localparam int unsigned MAXC    = 32;
    localparam int unsigned SA      = 0;
    localparam int          PCMOD   = 1 << PW;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b1;
    logic          START = 1'b0;
    logic          STALL = 1'b0;
    logic          BRANCH = 1'b0;
    logic [8:0]    bOFFSET = '0;
    logic          bSIGN = 1'b0;
    logic          ALU_RST = 1'b0;
    logic          ALU_HALT = 1'b0;
    logic [PW-1:0] PC;
    logic          COMMIT;
    logic          DONE;
    logic          TIMEOUT;
    logic [CW-1:0] INSTR_CNT;
    logic [1:0]    STATE;

    int errors = 0;
    int checks = 0;

    // Reference model: 0 = idle, 1 = run, 2 = halted
    int m_state;
    int m_pc;
    int m_cnt;
    int m_cyc;
    bit m_to;

    pc_sequencer #(
        .PW         (PW),
        .START_ADDR (SA),
        .CW         (CW),
        .MAX_CYCLES (MAXC)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .START     (START),
        .STALL     (STALL),
        .BRANCH    (BRANCH),
        .bOFFSET   (bOFFSET),
        .bSIGN     (bSIGN),
        .ALU_RST   (ALU_RST),
        .ALU_HALT  (ALU_HALT),
        .PC        (PC),
        .COMMIT    (COMMIT),
        .DONE      (DONE),
        .TIMEOUT   (TIMEOUT),
        .INSTR_CNT (INSTR_CNT),
        .STATE     (STATE)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_state = 0; m_pc = SA; m_cnt = 0; m_cyc = 0; m_to = 0;
    endtask

    task automatic model_edge();
        bit ret, hreq, wd;
        if (!RESET_N) begin
            model_reset();
            return;
        end
        if (m_state == 0 || m_state == 2) begin
            if (START) begin
                m_state = 1; m_pc = SA; m_cnt = 0; m_cyc = 0; m_to = 0;
            end
        end else begin
            ret  = !STALL;
            hreq = ret && ALU_RST && ALU_HALT;
            wd   = (m_cyc + 1 == MAXC);
            m_cyc++;
            if (ret && m_cnt < CNT_MAX) m_cnt++;
            if (hreq || wd) begin
                m_state = 2;
                if (!hreq) m_to = 1;
            end else if (ret) begin
                if (ALU_RST) m_pc = SA;
                else if (BRANCH) m_pc = (m_pc + PCMOD + (bSIGN ? -int'(bOFFSET) : int'(bOFFSET))) % PCMOD;
                else m_pc = (m_pc + 1) % PCMOD;
            end
        end
    endtask

    task automatic drive(input bit st, input bit sl, input bit br, input int off,
                         input bit sg, input bit rs, input bit ht);
        START = st; STALL = sl; BRANCH = br; bOFFSET = off[8:0];
        bSIGN = sg; ALU_RST = rs; ALU_HALT = ht;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #2 RESET_N = 1'b0;
        model_reset();
        #1;
        checks++; if (PC !== 10'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", PC); end
        checks++; if (STATE !== 2'b00) begin errors++; $display("FAIL reset_state: got %0d expected 0", STATE); end
        checks++; if (INSTR_CNT !== '0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", INSTR_CNT); end
        checks++; if (TIMEOUT !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", TIMEOUT); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", DONE); end
        checks++; if (COMMIT !== 1'b0) begin errors++; $display("FAIL reset_commit: got %b expected 0", COMMIT); end
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic test_sequential();
        drive(1, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (COMMIT !== 1'b0) begin errors++; $display("FAIL idle_commit: got %b expected 0", COMMIT); end
        tick();
        checks++; if (STATE !== 2'b01 || PC !== 10'd0) begin errors++; $display("FAIL start_run: state %0d pc %0d expected state 1 pc 0", STATE, PC); end
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            #1;
            checks++; if (COMMIT !== 1'b1) begin errors++; $display("FAIL seq_commit: got %b expected 1 at step %0d", COMMIT, i); end
            tick();
            checks++; if (PC !== i[PW-1:0] || PC !== m_pc[PW-1:0]) begin errors++; $display("FAIL seq_pc: got %0d expected %0d", PC, i); end
            checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL seq_done: got %b expected 0", DONE); end
        end
        checks++; if (INSTR_CNT !== 5'd5) begin errors++; $display("FAIL seq_cnt: got %0d expected 5", INSTR_CNT); end
    endtask

    task automatic test_branch();
        int offs[5] = '{3, 4, 4, 3, 8};
        bit sgns[5] = '{1, 0, 1, 1, 0};
        int exps[5] = '{2, 6, 2, 1023, 7};
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, offs[i], sgns[i], 0, 0);
            tick();
            checks++; if (PC !== exps[i][PW-1:0] || PC !== m_pc[PW-1:0]) begin errors++; $display("FAIL branch_pc: got %0d expected %0d (case %0d)", PC, exps[i], i); end
        end
        checks++; if (INSTR_CNT !== 5'd10) begin errors++; $display("FAIL branch_cnt: got %0d expected 10", INSTR_CNT); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 5, 0, 1, 1);
            #1;
            checks++; if (COMMIT !== 1'b0) begin errors++; $display("FAIL stall_commit: got %b expected 0", COMMIT); end
            tick();
            checks++; if (PC !== 10'd7 || INSTR_CNT !== 5'd10) begin errors++; $display("FAIL stall_hold: pc %0d cnt %0d expected pc 7 cnt 10", PC, INSTR_CNT); end
            checks++; if (STATE !== 2'b01 || DONE !== 1'b0) begin errors++; $display("FAIL stall_nohalt: state %0d done %b expected state 1 done 0", STATE, DONE); end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        checks++; if (PC !== 10'd8 || INSTR_CNT !== 5'd11) begin errors++; $display("FAIL stall_release: pc %0d cnt %0d expected pc 8 cnt 11", PC, INSTR_CNT); end
    endtask

    task automatic test_soft_reset();
        drive(0, 0, 1, 12, 0, 0, 0);
        tick();
        checks++; if (PC !== 10'd20) begin errors++; $display("FAIL sr_setup_pc: got %0d expected 20", PC); end
        drive(0, 0, 1, 7, 0, 1, 0);
        tick();
        checks++; if (PC !== 10'd0 || STATE !== 2'b01 || INSTR_CNT !== 5'd13) begin errors++; $display("FAIL soft_reset: pc %0d state %0d cnt %0d expected pc 0 state 1 cnt 13", PC, STATE, INSTR_CNT); end
        drive(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        drive(0, 0, 0, 0, 0, 1, 1);
        #1;
        checks++; if (COMMIT !== 1'b1) begin errors++; $display("FAIL halt_commit: got %b expected 1", COMMIT); end
        tick();
        checks++; if (DONE !== 1'b1 || STATE !== 2'b10) begin errors++; $display("FAIL halt_done: done %b state %0d expected done 1 state 2", DONE, STATE); end
        checks++; if (PC !== 10'd2 || INSTR_CNT !== 5'd16) begin errors++; $display("FAIL halt_hold: pc %0d cnt %0d expected pc 2 cnt 16", PC, INSTR_CNT); end
        checks++; if (TIMEOUT !== 1'b0) begin errors++; $display("FAIL halt_timeout: got %b expected 0", TIMEOUT); end
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (COMMIT !== 1'b0) begin errors++; $display("FAIL halted_commit: got %b expected 0", COMMIT); end
        tick();
        checks++; if (DONE !== 1'b1 || PC !== 10'd2) begin errors++; $display("FAIL halted_hold: done %b pc %0d expected done 1 pc 2", DONE, PC); end
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        checks++; if (PC !== 10'd0 || INSTR_CNT !== 5'd0 || DONE !== 1'b0 || STATE !== 2'b01) begin errors++; $display("FAIL restart: pc %0d cnt %0d done %b state %0d expected 0 0 0 1", PC, INSTR_CNT, DONE, STATE); end
    endtask

    task automatic test_start_ignored();
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            tick();
            checks++; if (PC !== i[PW-1:0] || INSTR_CNT !== i[CW-1:0]) begin errors++; $display("FAIL start_in_run: pc %0d cnt %0d expected %0d", PC, INSTR_CNT, i); end
        end
        drive(0, 0, 0, 0, 0, 1, 1);
        tick();
        checks++; if (STATE !== 2'b10 || INSTR_CNT !== 5'd4) begin errors++; $display("FAIL start_in_run_halt: state %0d cnt %0d expected state 2 cnt 4", STATE, INSTR_CNT); end
    endtask

    task automatic test_watchdog();
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= int'(MAXC); i++) begin
            tick();
            if (i < int'(MAXC)) begin
                checks++; if (STATE !== 2'b01 || PC !== 10'd0 || DONE !== 1'b0) begin errors++; $display("FAIL wd_loop: state %0d pc %0d done %b expected 1 0 0 at cycle %0d", STATE, PC, DONE, i); end
            end
        end
        checks++; if (STATE !== 2'b10 || DONE !== 1'b1 || TIMEOUT !== 1'b1) begin errors++; $display("FAIL wd_fire: state %0d done %b timeout %b expected 2 1 1", STATE, DONE, TIMEOUT); end
        checks++; if (INSTR_CNT !== 5'd31) begin errors++; $display("FAIL cnt_saturate: got %0d expected 31", INSTR_CNT); end
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        checks++; if (TIMEOUT !== 1'b0 || STATE !== 2'b01) begin errors++; $display("FAIL wd_clear: timeout %b state %0d expected 0 1", TIMEOUT, STATE); end
    endtask

    task automatic test_wd_with_halt();
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0);
            tick();
        end
        for (int i = 0; i < 21; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        checks++; if (STATE !== 2'b01 || PC !== 10'd21) begin errors++; $display("FAIL wdh_pre: state %0d pc %0d expected 1 21", STATE, PC); end
        drive(0, 0, 0, 0, 0, 1, 1);
        tick();
        checks++; if (STATE !== 2'b10 || TIMEOUT !== 1'b0) begin errors++; $display("FAIL wdh_timeout: state %0d timeout %b expected 2 0", STATE, TIMEOUT); end
        checks++; if (INSTR_CNT !== 5'd22 || PC !== 10'd21) begin errors++; $display("FAIL wdh_retire: cnt %0d pc %0d expected 22 21", INSTR_CNT, PC); end
    endtask

    task automatic test_async_reset();
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 12, 0, 0, 0);
        tick();
        checks++; if (PC !== 10'd12) begin errors++; $display("FAIL ar_setup: got %0d expected 12", PC); end
        drive(1, 0, 0, 0, 0, 0, 0);
        #2 RESET_N = 1'b0;
        model_reset();
        #1;
        checks++; if (PC !== 10'd0 || STATE !== 2'b00 || INSTR_CNT !== 5'd0) begin errors++; $display("FAIL async_reset: pc %0d state %0d cnt %0d expected 0 0 0", PC, STATE, INSTR_CNT); end
        checks++; if (COMMIT !== 1'b0 || DONE !== 1'b0) begin errors++; $display("FAIL async_reset_outs: commit %b done %b expected 0 0", COMMIT, DONE); end
        tick();
        checks++; if (STATE !== 2'b00 || PC !== 10'd0) begin errors++; $display("FAIL reset_held: state %0d pc %0d expected 0 0", STATE, PC); end
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0, 0);
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            START    = ($urandom_range(0, 7) == 0);
            STALL    = ($urandom_range(0, 3) == 0);
            BRANCH   = ($urandom_range(0, 2) == 0);
            bOFFSET  = 9'($urandom);
            bSIGN    = 1'($urandom);
            ALU_RST  = ($urandom_range(0, 11) == 0);
            ALU_HALT = 1'($urandom);
            #1;
            checks++; if (COMMIT !== (m_state == 1 && !STALL)) begin errors++; $display("FAIL rnd_commit: got %b expected %b at iter %0d", COMMIT, (m_state == 1 && !STALL), n); end
            tick();
            checks++; if (PC !== m_pc[PW-1:0]) begin errors++; $display("FAIL rnd_pc: got %0d expected %0d at iter %0d", PC, m_pc, n); end
            checks++; if (STATE !== m_state[1:0]) begin errors++; $display("FAIL rnd_state: got %0d expected %0d at iter %0d", STATE, m_state, n); end
            checks++; if (INSTR_CNT !== m_cnt[CW-1:0]) begin errors++; $display("FAIL rnd_cnt: got %0d expected %0d at iter %0d", INSTR_CNT, m_cnt, n); end
            checks++; if (DONE !== (m_state == 2)) begin errors++; $display("FAIL rnd_done: got %b expected %b at iter %0d", DONE, (m_state == 2), n); end
            checks++; if (TIMEOUT !== m_to) begin errors++; $display("FAIL rnd_timeout: got %b expected %b at iter %0d", TIMEOUT, m_to, n); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_soft_reset();
        test_start_ignored();
        test_watchdog();
        test_wd_with_halt();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
